// File: rtl/step_counter_p.sv
// step_counter_p: bounded up/down step counter with wrap, saturate and bounce boundary modes.
module step_counter_p #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              evt,
  output logic              cfg_err
);
  logic [WIDTH-1:0] step_n, count_n, clamp;
  logic [WIDTH:0]   sum, lim;
  logic             sat, bnc, up, cfg_bad, dir_n, evt_n;
  assign sat     = mode == 2'b01;
  assign bnc     = mode == 2'b10;
  assign cfg_bad = lo > hi;
  assign step_n  = WIDTH'(step);
  assign sum     = {1'b0, count} + {1'b0, step_n};
  assign lim     = {1'b0, lo} + {1'b0, step_n};
  assign clamp   = load_val < lo ? lo : load_val > hi ? hi : load_val;
  // bounce ignores up_down and steers from the stored direction
  assign up      = bnc ? dir : up_down;
  always_comb begin
    count_n = count;
    dir_n   = dir;
    evt_n   = 1'b0;
    if (!cfg_bad && load) begin
      count_n = clamp;
      dir_n   = up_down;
    end else if (!cfg_bad && en) begin
      dir_n = up;
      if (count < lo || count > hi) begin
        count_n = lo;
        dir_n   = up_down;
        evt_n   = 1'b1;
      end else if (step != '0) begin
        if (up) begin
          if (sum <= {1'b0, hi}) count_n = sum[WIDTH-1:0];
          else begin
            count_n = (sat || bnc) ? hi : lo;
            evt_n   = !sat || count != hi;
            if (bnc) dir_n = 1'b0;
          end
        end else begin
          if ({1'b0, count} >= lim) count_n = count - step_n;
          else begin
            count_n = (sat || bnc) ? lo : hi;
            evt_n   = !sat || count != lo;
            if (bnc) dir_n = 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      dir     <= 1'b1;
      evt     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      count   <= count_n;
      dir     <= dir_n;
      evt     <= evt_n;
      cfg_err <= cfg_bad;
    end
  end
endmodule

// File: tb/tb_step_counter_p.sv
// tb_step_counter_p: directed scenario tests for step_counter_p with hand-computed expectations.
module tb_step_counter_p;
  logic       clk = 1'b0;
  logic       rst, en, up_down, load;
  logic [3:0] step;
  logic [1:0] mode;
  logic [7:0] lo, hi, load_val, count;
  logic       dir, evt, cfg_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  step_counter_p #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .mode(mode),
    .lo(lo), .hi(hi), .load(load), .load_val(load_val),
    .count(count), .dir(dir), .evt(evt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; en = 1; up_down = 0; step = 4'd3; mode = 2'b00;
    lo = 8'd0; hi = 8'd100; load = 1; load_val = 8'd50;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL reset_prio got %0d/%b/%b/%b want 0/1/0/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_first_enable;
    rst = 0; load = 0; en = 1; up_down = 1; step = 4'd1; lo = 8'd5; hi = 8'd20;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd5, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL first_en got %0d/%b/%b/%b want 5/1/1/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_wrap;
    lo = 8'd10; hi = 8'd20; load = 1; load_val = 8'd18; en = 0; up_down = 1; mode = 2'b00; step = 4'd3;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd18, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL wrap_load got %0d/%b/%b/%b want 18/1/0/0", count, dir, evt, cfg_err); end
    load = 0; en = 1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd10, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_up got %0d/%b/%b/%b want 10/1/1/0", count, dir, evt, cfg_err); end
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd13, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL wrap_step got %0d/%b/%b/%b want 13/1/0/0", count, dir, evt, cfg_err); end
    up_down = 0; step = 4'd5;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd20, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL wrap_down got %0d/%b/%b/%b want 20/0/1/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_saturate;
    lo = 8'd0; hi = 8'd255; load = 1; load_val = 8'd250; en = 0; up_down = 1; mode = 2'b01; step = 4'd15;
    tick;
    load = 0; en = 1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd255, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sat_up got %0d/%b/%b/%b want 255/1/1/0", count, dir, evt, cfg_err); end
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd255, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL sat_hold got %0d/%b/%b/%b want 255/1/0/0", count, dir, evt, cfg_err); end
    load = 1; load_val = 8'd3; en = 0; up_down = 0; step = 4'd4;
    tick;
    load = 0; en = 1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sat_down got %0d/%b/%b/%b want 0/0/1/0", count, dir, evt, cfg_err); end
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL sat_lo_hold got %0d/%b/%b/%b want 0/0/0/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_bounce;
    lo = 8'd0; hi = 8'd9; load = 1; load_val = 8'd7; en = 0; up_down = 1; mode = 2'b10; step = 4'd4;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd7, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL bnc_load got %0d/%b/%b/%b want 7/1/0/0", count, dir, evt, cfg_err); end
    load = 0; en = 1; up_down = 0;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd9, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL bnc_top got %0d/%b/%b/%b want 9/0/1/0", count, dir, evt, cfg_err); end
    up_down = 1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd5, 1'b0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL bnc_5 got %0d/%b/%b/%b want 5/0/0/0", count, dir, evt, cfg_err); end
    up_down = 0;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd1, 1'b0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL bnc_1 got %0d/%b/%b/%b want 1/0/0/0", count, dir, evt, cfg_err); end
    up_down = 1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd0, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL bnc_bot got %0d/%b/%b/%b want 0/1/1/0", count, dir, evt, cfg_err); end
    up_down = 0;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd4, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL bnc_4 got %0d/%b/%b/%b want 4/1/0/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_cfg_err;
    lo = 8'd30; hi = 8'd20; load = 1; load_val = 8'd7; en = 1; up_down = 0;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd4, 1'b1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL cfg_bad got %0d/%b/%b/%b want 4/1/0/1", count, dir, evt, cfg_err); end
    lo = 8'd5; load = 0; mode = 2'b00; up_down = 1; step = 4'd1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd5, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL cfg_clear got %0d/%b/%b/%b want 5/1/1/0", count, dir, evt, cfg_err); end
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd6, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL cfg_resume got %0d/%b/%b/%b want 6/1/0/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_load_clamp;
    lo = 8'd10; hi = 8'd20; load = 1; load_val = 8'd99; en = 0; up_down = 1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd20, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL clamp_hi got %0d/%b/%b/%b want 20/1/0/0", count, dir, evt, cfg_err); end
    load_val = 8'd3; up_down = 0;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd10, 1'b0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL clamp_lo got %0d/%b/%b/%b want 10/0/0/0", count, dir, evt, cfg_err); end
    load_val = 8'd99; up_down = 1;
    tick;
    load = 0; hi = 8'd15; en = 1; step = 4'd1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd10, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL out_of_range got %0d/%b/%b/%b want 10/1/1/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_hold;
    en = 0; up_down = 0; step = 4'd2;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd10, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL en_hold got %0d/%b/%b/%b want 10/1/0/0", count, dir, evt, cfg_err); end
    en = 1; up_down = 1; step = 4'd0;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd10, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL step0 got %0d/%b/%b/%b want 10/1/0/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_lo_eq_hi;
    lo = 8'd7; hi = 8'd7; en = 1; up_down = 1; step = 4'd2; mode = 2'b00;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd7, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL eq_enter got %0d/%b/%b/%b want 7/1/1/0", count, dir, evt, cfg_err); end
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd7, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL eq_wrap got %0d/%b/%b/%b want 7/1/1/0", count, dir, evt, cfg_err); end
    mode = 2'b01;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd7, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL eq_sat got %0d/%b/%b/%b want 7/1/0/0", count, dir, evt, cfg_err); end
    mode = 2'b10;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd7, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL eq_bnc_up got %0d/%b/%b/%b want 7/0/1/0", count, dir, evt, cfg_err); end
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd7, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL eq_bnc_dn got %0d/%b/%b/%b want 7/1/1/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_mode3;
    lo = 8'd0; hi = 8'd9; load = 1; load_val = 8'd8; en = 0; up_down = 1; mode = 2'b11; step = 4'd3;
    tick;
    load = 0; en = 1;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd0, 1'b1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL mode3_wrap got %0d/%b/%b/%b want 0/1/1/0", count, dir, evt, cfg_err); end
  endtask

  task automatic test_rst_mid;
    load = 1; load_val = 8'd9; en = 0; up_down = 0;
    tick;
    rst = 1; load = 0; en = 1; up_down = 1; step = 4'd3; mode = 2'b10; lo = 8'd50; hi = 8'd40;
    tick;
    n_cmp++; if ({count, dir, evt, cfg_err} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL rst_mid got %0d/%b/%b/%b want 0/1/0/0", count, dir, evt, cfg_err); end
    rst = 0;
  endtask

  initial begin
    test_reset;
    test_first_enable;
    test_wrap;
    test_saturate;
    test_bounce;
    test_cfg_err;
    test_load_clamp;
    test_hold;
    test_lo_eq_hi;
    test_mode3;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
